boid_neighbor_accum: RTL and testbench

Upstream stage of the neighbour-count-to-shift lookup in the boids flocking pipeline. For one "self" boid, it scans a stream of other boids and keeps those strictly inside the visual range. It accumulates their positions and velocities, drives the neighbour count to the lookup, and applies the returned shift amount. The result is an approximate average: the sums are arithmetically right-shifted rather than divided. The averages feed the cohesion and alignment update stages.

---
 rtl/boid_neighbor_accum_if.sv | 36 +++
 rtl/boid_neighbor_accum.sv | 191 +++++++++++++++++++
 tb/tb_boid_neighbor_accum.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boid_neighbor_accum_if.sv
// rtl/boid_neighbor_accum_if.sv - beat and result streams for the boid neighbour accumulator
//
// Purpose: bundles the other-boid beat stream (in_*) and the averaged result
// stream (out_valid/out_ready, avg_*, neighbor_cnt) of boid_neighbor_accum.
// Ports (modports):
//   master - producer of beats and consumer of results (testbench / upstream)
//   slave  - the accumulator itself

interface boid_neighbor_accum_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [26:0] in_x;
    logic signed [26:0] in_y;
    logic signed [26:0] in_vx;
    logic signed [26:0] in_vy;
    logic               in_is_self;
    logic               in_last;

    logic               out_valid;
    logic               out_ready;
    logic signed [26:0] avg_x;
    logic signed [26:0] avg_y;
    logic signed [26:0] avg_vx;
    logic signed [26:0] avg_vy;
    logic [3:0]         neighbor_cnt;

    modport master (
        output in_valid, in_x, in_y, in_vx, in_vy, in_is_self, in_last, out_ready,
        input  in_ready, out_valid, avg_x, avg_y, avg_vx, avg_vy, neighbor_cnt
    );

    modport slave (
        input  in_valid, in_x, in_y, in_vx, in_vy, in_is_self, in_last, out_ready,
        output in_ready, out_valid, avg_x, avg_y, avg_vx, avg_vy, neighbor_cnt
    );
endinterface

// File: rtl/boid_neighbor_accum.sv
// rtl/boid_neighbor_accum.sv - accumulates in-range neighbour positions/velocities and shifts to averages
//
// Purpose: for one self boid, scans a stream of other boids, counts those whose
// squared distance is strictly below range_sq (self beat excluded, count capped
// at MAX_NEIGHBORS), sums their positions and velocities, and arithmetically
// shifts the sums by the amount returned by the count lookup.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  scan start pulse (IDLE only)
//   self_x, self_y         self position, latched on start
//   range_sq               squared visual range, latched on start
//   neighboring_boids      running neighbour count to the lookup
//   neighboring_boids_val  shift amount from the lookup (bits [1:0] used)
//   bus                    beat stream in, averaged result stream out

module boid_neighbor_accum #(
    parameter int MAX_NEIGHBORS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [26:0]  self_x,
    input  logic signed [26:0]  self_y,
    input  logic [56:0]         range_sq,
    output logic signed [26:0]  neighboring_boids,
    input  logic signed [26:0]  neighboring_boids_val,
    boid_neighbor_accum_if.slave bus
);

    localparam logic [3:0]         MAX_CNT = 4'(MAX_NEIGHBORS);
    localparam logic signed [30:0] SAT_HI  = 31'sd67108863;
    localparam logic signed [30:0] SAT_LO  = -31'sd67108864;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, SHIFT, DONE} state_t;

    state_t state;
    state_t state_next;

    logic signed [26:0] self_x_q;
    logic signed [26:0] self_y_q;
    logic [56:0]        range_q;

    // stage 1 registers
    logic               s1_valid;
    logic               s1_is_self;
    logic [55:0]        s1_dx2;
    logic [55:0]        s1_dy2;
    logic signed [26:0] s1_x;
    logic signed [26:0] s1_y;
    logic signed [26:0] s1_vx;
    logic signed [26:0] s1_vy;

    // accumulators
    logic [3:0]         count;
    logic signed [30:0] sum_x;
    logic signed [30:0] sum_y;
    logic signed [30:0] sum_vx;
    logic signed [30:0] sum_vy;

    // result registers
    logic signed [26:0] avg_x_q;
    logic signed [26:0] avg_y_q;
    logic signed [26:0] avg_vx_q;
    logic signed [26:0] avg_vy_q;
    logic [3:0]         cnt_q;

    logic               accept;
    logic signed [27:0] dx;
    logic signed [27:0] dy;
    logic signed [55:0] dx_sq;
    logic signed [55:0] dy_sq;
    logic [56:0]        dist_sq;
    logic               hit;
    logic [1:0]         sh;
    logic               unused_val_bits;

    function automatic logic signed [26:0] sat27(input logic signed [30:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[26:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[26:0];
        end else begin
            return v[26:0];
        end
    endfunction

    assign accept  = (state == ACCUM) && bus.in_valid;
    assign dx      = {bus.in_x[26], bus.in_x} - {self_x_q[26], self_x_q};
    assign dy      = {bus.in_y[26], bus.in_y} - {self_y_q[26], self_y_q};
    // squares of signed values are never negative, so the 56-bit pattern is the unsigned square
    assign dx_sq   = dx * dx;
    assign dy_sq   = dy * dy;
    assign dist_sq = {1'b0, s1_dx2} + {1'b0, s1_dy2};
    assign hit     = s1_valid && (dist_sq < range_q) && !s1_is_self && (count < MAX_CNT);
    assign sh      = neighboring_boids_val[1:0];
    assign unused_val_bits = ^neighboring_boids_val[26:2];

    assign neighboring_boids = {23'd0, count};
    assign bus.in_ready      = (state == ACCUM);
    assign bus.out_valid     = (state == DONE);
    assign bus.avg_x         = avg_x_q;
    assign bus.avg_y         = avg_y_q;
    assign bus.avg_vx        = avg_vx_q;
    assign bus.avg_vy        = avg_vy_q;
    assign bus.neighbor_cnt  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (bus.in_valid && bus.in_last) state_next = DRAIN;
            DRAIN:   state_next = SHIFT;
            SHIFT:   state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            self_x_q   <= '0;
            self_y_q   <= '0;
            range_q    <= '0;
            s1_valid   <= 1'b0;
            s1_is_self <= 1'b0;
            s1_dx2     <= '0;
            s1_dy2     <= '0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_vx      <= '0;
            s1_vy      <= '0;
            count      <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            sum_vx     <= '0;
            sum_vy     <= '0;
            avg_x_q    <= '0;
            avg_y_q    <= '0;
            avg_vx_q   <= '0;
            avg_vy_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (state == IDLE && start) begin
                self_x_q <= self_x;
                self_y_q <= self_y;
                range_q  <= range_sq;
                s1_valid <= 1'b0;
                count    <= '0;
                sum_x    <= '0;
                sum_y    <= '0;
                sum_vx   <= '0;
                sum_vy   <= '0;
            end else begin
                s1_valid <= accept;
                if (accept) begin
                    s1_dx2     <= dx_sq;
                    s1_dy2     <= dy_sq;
                    s1_x       <= bus.in_x;
                    s1_y       <= bus.in_y;
                    s1_vx      <= bus.in_vx;
                    s1_vy      <= bus.in_vy;
                    s1_is_self <= bus.in_is_self;
                end
                if (hit) begin
                    count  <= count + 4'd1;
                    sum_x  <= sum_x  + {{4{s1_x[26]}},  s1_x};
                    sum_y  <= sum_y  + {{4{s1_y[26]}},  s1_y};
                    sum_vx <= sum_vx + {{4{s1_vx[26]}}, s1_vx};
                    sum_vy <= sum_vy + {{4{s1_vy[26]}}, s1_vy};
                end
            end
            // count is final by SHIFT, so the lookup's shift matches it here
            if (state == SHIFT) begin
                avg_x_q  <= sat27(sum_x  >>> sh);
                avg_y_q  <= sat27(sum_y  >>> sh);
                avg_vx_q <= sat27(sum_vx >>> sh);
                avg_vy_q <= sat27(sum_vy >>> sh);
                cnt_q    <= count;
            end
        end
    end

endmodule

// File: tb/tb_boid_neighbor_accum.sv
// tb/tb_boid_neighbor_accum.sv - self-checking bench for boid_neighbor_accum

module tb_boid_neighbor_accum;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [26:0] self_x;
    logic signed [26:0] self_y;
    logic [56:0]        range_sq;
    logic signed [26:0] nb;
    logic signed [26:0] nb_val;

    boid_neighbor_accum_if bus();

    boid_neighbor_accum #(.MAX_NEIGHBORS(10)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .self_x                (self_x),
        .self_y                (self_y),
        .range_sq              (range_sq),
        .neighboring_boids     (nb),
        .neighboring_boids_val (nb_val),
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    // neighbour-count-to-shift lookup: roughly log2 of the count
    function automatic int lut(input int c);
        if (c < 2)      return 0;
        else if (c < 4) return 1;
        else if (c < 8) return 2;
        else            return 3;
    endfunction

    assign nb_val = 27'(lut(int'(nb)));

    typedef struct {
        longint x, y, vx, vy;
        bit     is_self, last;
    } beat_t;

    typedef struct {
        longint sx, sy, rsq;
        longint x, y, vx, vy;
        bit     is_self, last;
        int     gap;
        int     ecnt;
        longint eax, eay, eavx, eavy;
    } tvec_t;

    beat_t beats[$];
    tvec_t tv[$];
    int    pass_cnt = 0;
    int    chk_cnt  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    function automatic longint sat27(input longint v);
        if (v > 67108863)       return 67108863;
        else if (v < -67108864) return -67108864;
        else                    return v;
    endfunction

    // reference: filter, cap, sum, then divide-by-shift from the lookup
    task automatic model(input longint sx, input longint sy, input longint rsq,
                         output int cnt, output longint ax, output longint ay,
                         output longint avx, output longint avy);
        longint tx = 0, ty = 0, tvx = 0, tvy = 0;
        int s;
        cnt = 0;
        foreach (beats[i]) begin
            longint ddx = beats[i].x - sx;
            longint ddy = beats[i].y - sy;
            if ((ddx * ddx + ddy * ddy) < rsq && !beats[i].is_self && cnt < 10) begin
                cnt++;
                tx += beats[i].x; ty += beats[i].y;
                tvx += beats[i].vx; tvy += beats[i].vy;
            end
        end
        s   = lut(cnt);
        ax  = sat27(tx >>> s);
        ay  = sat27(ty >>> s);
        avx = sat27(tvx >>> s);
        avy = sat27(tvy >>> s);
    endtask

    task automatic send_beat(input beat_t b);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.in_x       = 27'(b.x);
        bus.in_y       = 27'(b.y);
        bus.in_vx      = 27'(b.vx);
        bus.in_vy      = 27'(b.vy);
        bus.in_is_self = b.is_self;
        bus.in_last    = b.last;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // entered and left at a negedge with the DUT idle
    task automatic run_scan(input string tag, input longint sx, input longint sy, input longint rsq,
                            input int gap, input int hold, input int ecnt,
                            input longint eax, input longint eay, input longint eavx, input longint eavy);
        int cyc;
        start    = 1'b1;
        self_x   = 27'(sx);
        self_y   = 27'(sy);
        range_sq = 57'(rsq);
        @(negedge clk);
        start = 1'b0;
        foreach (beats[i]) begin
            if (i > 0) repeat (gap) @(negedge clk);
            send_beat(beats[i]);
        end
        chk({tag, ".drain_ready"}, longint'(bus.in_ready), 0);
        cyc = 1;
        while (!bus.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 3);
        if (bus.out_valid) begin
            for (int h = 0; h < hold; h++) begin
                start  = (h % 2 == 0);
                self_x = 27'(h * 7 + 3);
                @(negedge clk);
                chk({tag, ".hold_valid"}, longint'(bus.out_valid), 1);
                chk({tag, ".hold_avg_x"}, longint'(bus.avg_x), eax);
            end
            start = 1'b0;
            chk({tag, ".cnt"},    longint'(bus.neighbor_cnt), ecnt);
            chk({tag, ".nb"},     longint'(nb), ecnt);
            chk({tag, ".avg_x"},  longint'(bus.avg_x), eax);
            chk({tag, ".avg_y"},  longint'(bus.avg_y), eay);
            chk({tag, ".avg_vx"}, longint'(bus.avg_vx), eavx);
            chk({tag, ".avg_vy"}, longint'(bus.avg_vy), eavy);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk({tag, ".released"}, longint'(bus.out_valid), 0);
            chk({tag, ".idle"}, longint'(bus.in_ready), 0);
        end
    endtask

    task automatic add_row(input longint sx, input longint sy, input longint rsq,
                           input longint x, input longint y, input longint vx, input longint vy,
                           input bit is_self, input bit last, input int gap, input int ecnt,
                           input longint eax, input longint eay, input longint eavx, input longint eavy);
        tvec_t r;
        r.sx = sx; r.sy = sy; r.rsq = rsq;
        r.x = x; r.y = y; r.vx = vx; r.vy = vy;
        r.is_self = is_self; r.last = last; r.gap = gap;
        r.ecnt = ecnt; r.eax = eax; r.eay = eay; r.eavx = eavx; r.eavy = eavy;
        tv.push_back(r);
    endtask

    task automatic push_beat(input longint x, input longint y, input longint vx, input longint vy,
                             input bit is_self, input bit last);
        beat_t b;
        b.x = x; b.y = y; b.vx = vx; b.vy = vy; b.is_self = is_self; b.last = last;
        beats.push_back(b);
    endtask

    initial begin
        longint big;
        int     first;
        int     rc;
        longint rax, ray, ravx, ravy, rsx, rsy, rrsq;

        big = 64'sd9007199254740992;  // 2^53
        // scan A: range strictness
        add_row(0, 0, 100, 3, 4, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, 100, 6, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, 100, 10, 0, 2, 0, 0, 1, 0, 2, 4, 2, 6, 0);
        // scan B: only the self beat
        add_row(5, 5, 100, 5, 5, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0);
        // scan C: extreme neighbour with 2-cycle gaps, scan D same without gaps
        add_row(0, 0, big, -67108864, 0, -67108864, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        add_row(0, 0, big, 3, 4, 8, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        add_row(0, 0, big, 5, 0, 2, 0, 0, 1, 2, 3, -33554428, 2, -33554427, 0);
        add_row(0, 0, big, -67108864, 0, -67108864, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, big, 3, 4, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, big, 5, 0, 2, 0, 0, 1, 0, 3, -33554428, 2, -33554427, 0);
        // scan E: saturation at both ends
        add_row(0, 0, big, -67108864, 0, 67108863, -5, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, big, -67108864, 0, 67108863, -5, 0, 0, 0, 0, 0, 0, 0, 0);
        add_row(0, 0, big, -67108864, 0, 67108863, -5, 0, 1, 0, 3, -67108864, 0, 67108863, -8);
        // scan F: off-origin self, boundary distance, self beat among neighbours
        add_row(100, -100, 50, 105, -105, 9, 9, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(100, -100, 50, 104, -105, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(100, -100, 50, 100, -100, 50, 50, 1, 0, 1, 0, 0, 0, 0, 0);
        add_row(100, -100, 50, 99, -99, -3, 1, 0, 1, 1, 2, 101, -102, 2, 1);

        rst_n = 1'b0; start = 1'b0; self_x = '0; self_y = '0; range_sq = '0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_vx = '0; bus.in_vy = '0;
        bus.in_is_self = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready",  longint'(bus.in_ready), 0);
        chk("rst.out_valid", longint'(bus.out_valid), 0);
        chk("rst.nb",        longint'(nb), 0);
        chk("rst.cnt",       longint'(bus.neighbor_cnt), 0);
        chk("rst.avg_x",     longint'(bus.avg_x), 0);
        chk("rst.avg_vy",    longint'(bus.avg_vy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        first = 0;
        for (int i = 0; i < tv.size(); i++) begin
            push_beat(tv[i].x, tv[i].y, tv[i].vx, tv[i].vy, tv[i].is_self, tv[i].last);
            if (tv[i].last) begin
                run_scan($sformatf("vec%0d", i), tv[first].sx, tv[first].sy, tv[first].rsq,
                         tv[i].gap, 0, tv[i].ecnt, tv[i].eax, tv[i].eay, tv[i].eavx, tv[i].eavy);
                beats.delete();
                first = i + 1;
            end
        end

        // 12 neighbours: count caps at 10
        for (int i = 0; i < 12; i++) push_beat(1, 1, -5, 0, 0, i == 11);
        run_scan("cap", 0, 0, 100, 0, 0, 10, 1, 1, -7, 0);
        beats.delete();

        // out_ready held low 5 cycles with start pulses in DONE, then a fresh scan
        push_beat(3, 4, 8, 0, 0, 0);
        push_beat(6, 0, 4, 0, 0, 0);
        push_beat(10, 0, 2, 0, 0, 1);
        run_scan("hold", 0, 0, 100, 0, 5, 2, 4, 2, 6, 0);
        beats.delete();
        push_beat(7, 7, 1, 2, 0, 1);
        run_scan("after_hold", 0, 0, 100, 0, 0, 1, 7, 7, 1, 2);
        beats.delete();

        // reset mid-ACCUM after 3 counted beats
        start = 1'b1; self_x = '0; self_y = '0; range_sq = 57'd1000;
        @(negedge clk);
        start = 1'b0;
        push_beat(1, 1, 2, 2, 0, 0);
        foreach (beats[i]) begin
            send_beat(beats[i]);
            send_beat(beats[i]);
            send_beat(beats[i]);
        end
        beats.delete();
        @(negedge clk);
        chk("abort.nb_before", longint'(nb), 3);
        rst_n = 1'b0;
        #1;
        chk("abort.nb",        longint'(nb), 0);
        chk("abort.in_ready",  longint'(bus.in_ready), 0);
        chk("abort.out_valid", longint'(bus.out_valid), 0);
        chk("abort.avg_x",     longint'(bus.avg_x), 0);
        chk("abort.cnt",       longint'(bus.neighbor_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_beat(2, 2, 4, 6, 0, 1);
        run_scan("post_abort", 0, 0, 1000, 0, 0, 1, 2, 2, 4, 6);
        beats.delete();

        // randomized scans against the reference model
        for (int s = 0; s < 25; s++) begin
            int n;
            rsx  = longint'($urandom_range(0, 2000)) - 1000;
            rsy  = longint'($urandom_range(0, 2000)) - 1000;
            rrsq = longint'($urandom_range(100, 2000));
            n    = int'($urandom_range(1, 14));
            for (int i = 0; i < n; i++) begin
                push_beat(rsx + longint'($urandom_range(0, 80)) - 40,
                          rsy + longint'($urandom_range(0, 80)) - 40,
                          longint'($urandom_range(0, 2000)) - 1000,
                          longint'($urandom_range(0, 2000)) - 1000,
                          $urandom_range(0, 7) == 0, i == n - 1);
            end
            model(rsx, rsy, rrsq, rc, rax, ray, ravx, ravy);
            run_scan($sformatf("rnd%0d", s), rsx, rsy, rrsq, int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), rc, rax, ray, ravx, ravy);
            beats.delete();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
